ws2812_bit_encoder: RTL and testbench

//  Serial line encoder directly downstream of pixel_bit_counter in the LED-strip driver.
//  - Owns the counter's RST; consumes its PIXEL/BIT/NS/DONE outputs.
//  - Fetches 24-bit GRB words from the frame RAM and drives the WS2812 data line
//    (high-pulse width per bit, MSB first).
//  - Finishes each frame with a low latch period, then reports frame completion.

---
 rtl/ws2812_bit_encoder.sv | 159 +++++++++++++++
 tb/tb_ws2812_bit_encoder.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_bit_encoder.sv
// WS2812 serial line encoder: fetches GRB words from frame RAM and shapes one high pulse
// per bit slot, timed by an external pixel/bit/tick counter, then holds a low latch period.
module ws2812_bit_encoder #(
   parameter int PIXELS      = 256,
   parameter int BITS        = 24,
   parameter int NSS         = 64,
   parameter int T0H         = 20,
   parameter int T1H         = 40,
   parameter int RESET_TICKS = 3200
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            start_i,
   input  logic [7:0]      pixel_i,
   input  logic [7:0]      bit_i,
   input  logic [7:0]      ns_i,
   input  logic            done_i,
   output logic            cnt_rst_o,
   output logic            rd_en_o,
   output logic [7:0]      rd_addr_o,
   input  logic [BITS-1:0] rd_data_i,
   output logic            dout_o,
   output logic            busy_o,
   output logic            frame_done_o,
   output logic [1:0]      state_o
);

   localparam int LW = $clog2(RESET_TICKS + 1);

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_PREFETCH = 2'd1,
      S_SEND     = 2'd2,
      S_LATCH    = 2'd3
   } state_t;

   state_t          state_q;
   logic            dout_q;
   logic            cnt_rst_q;
   logic            rd_en_q;
   logic            rd_valid_q;
   logic [7:0]      rd_addr_q;
   logic            busy_q;
   logic            frame_done_q;
   logic [BITS-1:0] cur_q;
   logic [BITS-1:0] next_q;
   logic [LW-1:0]   latch_cnt_q;

   // Index arithmetic is 9 bits wide so PIXELS=256 compares correctly against PIXEL+1.
   logic [8:0]      pixel_inc;
   logic [8:0]      bit_inc;
   logic [8:0]      ns_inc;
   logic [8:0]      bit_sel;
   logic [8:0]      high_ticks;
   logic [BITS-1:0] bit_mask;
   logic            last_bit;
   logic            last_tick;
   logic            first_tick;
   logic            more_pixels;
   logic            cur_bit;
   logic            dout_d;

   assign pixel_inc   = {1'b0, pixel_i} + 9'd1;
   assign bit_inc     = {1'b0, bit_i} + 9'd1;
   assign ns_inc      = {1'b0, ns_i} + 9'd1;
   assign last_bit    = (bit_inc == 9'(BITS));
   assign last_tick   = (ns_inc == 9'(NSS));
   assign first_tick  = (ns_i == 8'd0);
   assign more_pixels = (pixel_inc < 9'(PIXELS));

   // MSB first: bit index 0 selects CUR[BITS-1].
   assign bit_sel    = 9'(BITS - 1) - {1'b0, bit_i};
   assign bit_mask   = {{(BITS-1){1'b0}}, 1'b1} << bit_sel;
   assign cur_bit    = |(cur_q & bit_mask);
   assign high_ticks = cur_bit ? 9'(T1H) : 9'(T0H);
   assign dout_d     = ({1'b0, ns_i} < high_ticks);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= S_IDLE;
         dout_q       <= 1'b0;
         cnt_rst_q    <= 1'b1;
         rd_en_q      <= 1'b0;
         rd_valid_q   <= 1'b0;
         rd_addr_q    <= 8'd0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         cur_q        <= '0;
         next_q       <= '0;
         latch_cnt_q  <= '0;
      end else begin
         rd_en_q      <= 1'b0;
         rd_valid_q   <= rd_en_q;
         frame_done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               dout_q      <= 1'b0;
               cnt_rst_q   <= 1'b1;
               latch_cnt_q <= '0;
               if (start_i) begin
                  rd_en_q   <= 1'b1;
                  rd_addr_q <= 8'd0;
                  busy_q    <= 1'b1;
                  state_q   <= S_PREFETCH;
               end
            end
            // Hold until the first word arrives, then release the counter.
            S_PREFETCH: begin
               dout_q <= 1'b0;
               if (rd_valid_q) begin
                  cur_q     <= rd_data_i;
                  cnt_rst_q <= 1'b0;
                  state_q   <= S_SEND;
               end
            end
            S_SEND: begin
               dout_q <= dout_d;
               if (rd_valid_q) begin
                  next_q <= rd_data_i;
               end
               if (last_bit && first_tick && more_pixels) begin
                  rd_en_q   <= 1'b1;
                  rd_addr_q <= pixel_inc[7:0];
               end
               if (last_bit && last_tick) begin
                  cur_q <= next_q;
                  if (done_i) begin
                     cnt_rst_q   <= 1'b1;
                     latch_cnt_q <= '0;
                     state_q     <= S_LATCH;
                  end
               end
            end
            S_LATCH: begin
               dout_q <= 1'b0;
               if (latch_cnt_q == LW'(RESET_TICKS)) begin
                  frame_done_q <= 1'b1;
                  busy_q       <= 1'b0;
                  state_q      <= S_IDLE;
               end else begin
                  latch_cnt_q <= latch_cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign cnt_rst_o    = cnt_rst_q;
   assign rd_en_o      = rd_en_q;
   assign rd_addr_o    = rd_addr_q;
   assign dout_o       = dout_q;
   assign busy_o       = busy_q;
   assign frame_done_o = frame_done_q;
   assign state_o      = state_q;

endmodule

// File: tb/tb_ws2812_bit_encoder.sv
// Bench for ws2812_bit_encoder: behavioural pixel/bit/tick counter and 1-cycle RAM around
// the encoder, with directed frames checked slot by slot against hand-derived pulse widths.
module tb_ws2812_bit_encoder;

   localparam int PIXELS      = 2;
   localparam int BITS        = 24;
   localparam int NSS         = 64;
   localparam int T0H         = 20;
   localparam int T1H         = 40;
   localparam int RESET_TICKS = 100;
   localparam int FIRST_RISE  = 3;
   localparam int SLOTS       = PIXELS * BITS;
   localparam int FD_IDX      = FIRST_RISE + SLOTS * NSS + RESET_TICKS;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  c_pix;
   logic [7:0]  c_bit;
   logic [7:0]  c_ns;
   logic        c_done;
   logic        cnt_rst;
   logic        rd_en;
   logic [7:0]  rd_addr;
   logic [23:0] rd_data;
   logic        dout;
   logic        busy;
   logic        frame_done;
   logic [1:0]  state;
   logic [23:0] mem [0:255];

   int checks = 0;
   int errors = 0;

   logic       dout_log[$];
   logic [7:0] addr_log[$];
   int         fd_count;
   int         fd_idx;
   int         rd_b2b;
   logic       busy_first;
   logic       busy_at_fd;
   logic       cnt_rst_at_fd;

   logic [23:0] pat0 [3] = '{24'hFF0000, 24'hAAAAAA, 24'h000000};
   logic [23:0] pat1 [3] = '{24'h000001, 24'h555555, 24'hFFFFFF};

   ws2812_bit_encoder #(
      .PIXELS(PIXELS), .BITS(BITS), .NSS(NSS), .T0H(T0H), .T1H(T1H),
      .RESET_TICKS(RESET_TICKS)
   ) dut (
      .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
      .pixel_i(c_pix), .bit_i(c_bit), .ns_i(c_ns), .done_i(c_done),
      .cnt_rst_o(cnt_rst), .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_data_i(rd_data),
      .dout_o(dout), .busy_o(busy), .frame_done_o(frame_done), .state_o(state)
   );

   // Clock / reset block
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Upstream pixel/bit/tick counter model
   always @(posedge clk) begin
      if (cnt_rst) begin
         c_pix <= 8'd0;
         c_bit <= 8'd0;
         c_ns  <= 8'd0;
      end else if (c_ns == 8'(NSS - 1)) begin
         c_ns <= 8'd0;
         if (c_bit == 8'(BITS - 1)) begin
            c_bit <= 8'd0;
            c_pix <= (c_pix == 8'(PIXELS - 1)) ? 8'd0 : c_pix + 8'd1;
         end else begin
            c_bit <= c_bit + 8'd1;
         end
      end else begin
         c_ns <= c_ns + 8'd1;
      end
   end
   assign c_done = (c_pix == 8'(PIXELS - 1)) && (c_bit == 8'(BITS - 1));

   // Frame RAM, data one cycle after the read strobe
   always @(posedge clk) begin
      if (rd_en) rd_data <= mem[rd_addr];
   end

   function automatic int run_len(input int start_idx, input logic val);
      int n = 0;
      while ((start_idx + n) < dout_log.size() && dout_log[start_idx + n] === val) n++;
      return n;
   endfunction

   function automatic logic exp_bit(input logic [23:0] w0, input logic [23:0] w1, input int k);
      logic [23:0] w;
      w = (k < BITS) ? w0 : w1;
      return w[BITS - 1 - (k % BITS)];
   endfunction

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Records DOUT and read traffic from the negedge after START until a tail past FRAME_DONE.
   task automatic capture_frame(input int max_cycles, input int tail);
      logic prev_rd;
      dout_log.delete();
      addr_log.delete();
      fd_count = 0;
      fd_idx   = -1;
      rd_b2b   = 0;
      prev_rd  = 1'b0;
      for (int i = 0; i < max_cycles; i++) begin
         if (i > 0) @(negedge clk);
         dout_log.push_back(dout);
         if (i == 0) busy_first = busy;
         if (rd_en === 1'b1) begin
            addr_log.push_back(rd_addr);
            if (prev_rd) rd_b2b++;
         end
         prev_rd = rd_en;
         if (frame_done === 1'b1) begin
            fd_count++;
            if (fd_idx < 0) begin
               fd_idx        = i;
               busy_at_fd    = busy;
               cnt_rst_at_fd = cnt_rst;
            end
         end
         if (fd_idx >= 0 && i >= fd_idx + tail) break;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      start = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({dout, cnt_rst, busy, rd_en, frame_done} !== 5'b01000) begin
         errors++;
         $display("FAIL reset_outputs: got dout/cnt_rst/busy/rd_en/fd=%b expected 01000",
                  {dout, cnt_rst, busy, rd_en, frame_done});
      end
      checks++;
      if (rd_addr !== 8'd0 || state !== 2'd0) begin
         errors++;
         $display("FAIL reset_addr_state: got addr=%0d state=%0d expected 0 0", rd_addr, state);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if ({dout, cnt_rst, busy, rd_en, frame_done} !== 5'b01000) begin
            errors++;
            $display("FAIL idle_hold cycle %0d: got %b expected 01000", i,
                     {dout, cnt_rst, busy, rd_en, frame_done});
         end
      end
   endtask

   task automatic test_frames();
      for (int p = 0; p < 3; p++) begin
         mem[0] = pat0[p];
         mem[1] = pat1[p];
         pulse_start();
         capture_frame(FD_IDX + 200, 30);
         checks++;
         if (run_len(0, 1'b0) !== FIRST_RISE) begin
            errors++;
            $display("FAIL frame%0d first_rise: got %0d expected %0d", p, run_len(0, 1'b0), FIRST_RISE);
         end
         checks++;
         if (busy_first !== 1'b1) begin
            errors++;
            $display("FAIL frame%0d busy_start: got %b expected 1", p, busy_first);
         end
         for (int k = 0; k < SLOTS; k++) begin
            int s;
            int h;
            int l;
            int hexp;
            s    = FIRST_RISE + k * NSS;
            hexp = exp_bit(pat0[p], pat1[p], k) ? T1H : T0H;
            h    = run_len(s, 1'b1);
            l    = run_len(s + h, 1'b0);
            checks++;
            if (h !== hexp) begin
               errors++;
               $display("FAIL frame%0d slot%0d high: got %0d expected %0d", p, k, h, hexp);
            end
            checks++;
            if (k < SLOTS - 1 && l !== NSS - hexp) begin
               errors++;
               $display("FAIL frame%0d slot%0d low: got %0d expected %0d", p, k, l, NSS - hexp);
            end else if (k == SLOTS - 1 && l !== dout_log.size() - (s + h)) begin
               errors++;
               $display("FAIL frame%0d tail_low: got %0d expected %0d", p, l, dout_log.size() - (s + h));
            end
         end
         checks++;
         if (fd_idx !== FD_IDX || fd_count !== 1) begin
            errors++;
            $display("FAIL frame%0d frame_done: got idx=%0d count=%0d expected idx=%0d count=1",
                     p, fd_idx, fd_count, FD_IDX);
         end
         checks++;
         if (busy_at_fd !== 1'b0 || cnt_rst_at_fd !== 1'b1) begin
            errors++;
            $display("FAIL frame%0d fd_status: got busy=%b cnt_rst=%b expected 0 1",
                     p, busy_at_fd, cnt_rst_at_fd);
         end
         checks++;
         if (addr_log.size() !== 2 || addr_log[0] !== 8'd0 || addr_log[1] !== 8'd1 || rd_b2b !== 0) begin
            errors++;
            $display("FAIL frame%0d reads: got count=%0d b2b=%0d expected addresses 0,1 b2b=0",
                     p, addr_log.size(), rd_b2b);
         end
         repeat (10) @(negedge clk);
      end
   endtask

   task automatic test_start_ignored();
      mem[0] = 24'h123456;
      mem[1] = 24'hABCDEF;
      pulse_start();
      fork
         capture_frame(FD_IDX + 200, 30);
         begin
            repeat (6) begin
               repeat (499) @(negedge clk);
               start = 1'b1;
               @(negedge clk);
               start = 1'b0;
            end
         end
      join
      checks++;
      if (addr_log.size() !== 2 || fd_count !== 1 || fd_idx !== FD_IDX) begin
         errors++;
         $display("FAIL start_ignored: got reads=%0d fd_count=%0d fd_idx=%0d expected 2 1 %0d",
                  addr_log.size(), fd_count, fd_idx, FD_IDX);
      end
      for (int k = 0; k < SLOTS; k++) begin
         int h;
         int hexp;
         hexp = exp_bit(24'h123456, 24'hABCDEF, k) ? T1H : T0H;
         h    = run_len(FIRST_RISE + k * NSS, 1'b1);
         checks++;
         if (h !== hexp) begin
            errors++;
            $display("FAIL start_ignored slot%0d high: got %0d expected %0d", k, h, hexp);
         end
      end
      repeat (20) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || rd_en !== 1'b0) begin
         errors++;
         $display("FAIL start_not_queued: got busy=%b rd_en=%b expected 0 0", busy, rd_en);
      end
   endtask

   task automatic test_reset_mid_frame();
      int waited;
      mem[0] = 24'hAAAAAA;
      mem[1] = 24'h555555;
      pulse_start();
      waited = 0;
      while (!(c_pix == 8'd1 && c_bit == 8'd5 && c_ns == 8'd30) && waited < 4000) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (waited >= 4000) begin
         errors++;
         $display("FAIL midframe_reach: got timeout after %0d cycles expected pixel1 bit5 ns30", waited);
      end
      checks++;
      if (dout !== 1'b1) begin
         errors++;
         $display("FAIL midframe_dout_before: got %b expected 1", dout);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({dout, cnt_rst, busy, rd_en, frame_done} !== 5'b01000) begin
         errors++;
         $display("FAIL async_reset: got %b expected 01000", {dout, cnt_rst, busy, rd_en, frame_done});
      end
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         checks++;
         if (frame_done !== 1'b0 || dout !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abandoned_frame cycle %0d: got fd=%b dout=%b busy=%b expected 0 0 0",
                     i, frame_done, dout, busy);
         end
      end
      pulse_start();
      capture_frame(FD_IDX + 200, 30);
      checks++;
      if (run_len(0, 1'b0) !== FIRST_RISE || fd_idx !== FD_IDX) begin
         errors++;
         $display("FAIL replay_timing: got rise=%0d fd_idx=%0d expected %0d %0d",
                  run_len(0, 1'b0), fd_idx, FIRST_RISE, FD_IDX);
      end
      for (int k = 0; k < SLOTS; k++) begin
         int h;
         int hexp;
         hexp = exp_bit(24'hAAAAAA, 24'h555555, k) ? T1H : T0H;
         h    = run_len(FIRST_RISE + k * NSS, 1'b1);
         checks++;
         if (h !== hexp) begin
            errors++;
            $display("FAIL replay slot%0d high: got %0d expected %0d", k, h, hexp);
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 24'h000000;
      rst_n = 1'b0;
      start = 1'b0;
      test_reset();
      test_frames();
      test_start_ignored();
      test_reset_mid_frame();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
